// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch-stage state encodings, reset-PC default and NPC op codes.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_op_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_wdog.sv
// pcf_wdog: counts fetch-wait cycles; expired fires on the LIMIT-th tick since the last clear.
module pcf_wdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick) cnt <= cnt + 1'b1;

  assign expired = tick && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC register and req/ack instruction fetch stage of the SCPU.
// Optional fetch timeout fault enabled by PCF_TIMEOUT_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NPC,
  input  logic        core_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] inst_cnt,
  output logic        fetch_err
);

  state_t state, state_nx;
  logic   expired;

`ifdef PCF_TIMEOUT_EN
  pcf_wdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != S_REQ),
    .tick    (state == S_REQ && !imem_ack),
    .expired (expired)
  );
  assign fetch_err = state == S_ERR;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expired        = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // ack has priority over the timeout when both land in the same cycle
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE  ? S_REQ :
               state == S_REQ   ? (imem_ack ? S_VALID : expired ? S_ERR : S_REQ) :
               state == S_VALID ? (core_done ? S_REQ : S_VALID) :
               state;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= S_IDLE;
      PC       <= RESET_PC;
      instr    <= '0;
      inst_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == S_REQ && imem_ack) instr <= imem_rdata;
      if (state == S_VALID && core_done) begin
        PC       <= word_align(NPC);
        inst_cnt <= inst_cnt + 1'b1;
      end
    end

  assign imem_req    = state == S_REQ;
  assign imem_addr   = PC;
  assign instr_valid = state == S_VALID;

endmodule
